// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-side logic.
// Contents:
//   - ps2_state_t : host transmitter state encoding
//   - PS2_*_FE    : falling-edge numbers within a host-to-device frame
//   - CMD_*/RESP_*: common keyboard command and response bytes
//   - odd_parity  : parity bit that makes a data byte plus parity odd
// -----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    WAIT_IDLE = 3'd4
  } ps2_state_t;

  // Device clock falling edges in one host-to-device frame.
  localparam logic [3:0] PS2_FRAME_FE  = 4'd11;
  localparam logic [3:0] PS2_ACK_FE    = 4'd11;
  localparam logic [3:0] PS2_LAST_DATA = 4'd8;
  localparam logic [3:0] PS2_PARITY_FE = 4'd9;
  localparam logic [3:0] PS2_STOP_FE   = 4'd10;

  localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] RESP_ACK      = 8'hFA;

  // Odd parity: the returned bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] i_d);
    return ~^i_d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// -----------------------------------------------------------------------------
// ps2_line_sync
// Two-flop synchronizer plus registered falling-edge detector for one raw
// PS/2 line. Lines idle high, so all flops reset to the released level.
// Ports:
//   clk    in  system clock
//   rst_b  in  asynchronous active-low reset
//   i_line in  raw asynchronous line
//   o_sync out synchronized line level
//   o_fe   out one-cycle pulse, three clocks after the pin falls
// -----------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk,
  input  logic rst_b,
  input  logic i_line,
  output logic o_sync,
  output logic o_fe
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_fe;

  // Synchronizer chain and registered edge detect (prev=1, cur=0).
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
      r_fe   <= 1'b0;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fe   <= r_prev & ~r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fe   = r_fe;

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts start/data/parity/stop out on device clock falling edges and
// samples the device ACK. Shares the open-drain pair with the receiver.
// Optional build macro: PS2_TX_TIMEOUT_EN enables the frame timeout/abort.
// Ports:
//   clk          in  system clock
//   rst_b        in  asynchronous active-low reset
//   tx_data[7:0] in  byte to send
//   tx_valid     in  send request, taken when tx_valid && tx_ready
//   tx_ready     out high only in IDLE
//   ps2_clk_in   in  raw PS/2 clock line
//   ps2_data_in  in  raw PS/2 data line
//   ps2_clk_oe   out 1 pulls the clock line low
//   ps2_data_oe  out 1 pulls the data line low
//   busy         out high from acceptance until back in IDLE
//   rx_inhibit   out copy of busy, tells the receiver to drop frames
//   done         out one-cycle pulse at frame end
//   ack_ok       out valid with done, 1 when the device acknowledged
//   err          out one-cycle pulse on NACK or timeout
// -----------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQ_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_SIZE       = 20
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam logic [CNT_SIZE-1:0] C_ONE      = CNT_SIZE'(1);
  localparam logic [CNT_SIZE-1:0] C_INH_LAST = CNT_SIZE'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_SIZE-1:0] C_REQ_LAST = CNT_SIZE'(REQ_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_SIZE-1:0] C_TO_LAST  = CNT_SIZE'(TIMEOUT_CYCLES - 1);
`endif

  ps2_state_t          r_state;
  ps2_state_t          w_state_nxt;
  logic [CNT_SIZE-1:0] r_cnt;
  logic [CNT_SIZE-1:0] w_cnt_nxt;
  logic [3:0]          r_bit_cnt;
  logic [3:0]          w_bit_cnt_nxt;
  logic [3:0]          w_fe_num;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_nxt;
  logic                r_parity;
  logic                w_parity_nxt;
  logic                r_clk_oe;
  logic                w_clk_oe_nxt;
  logic                r_data_oe;
  logic                w_data_oe_nxt;
  logic                r_ack_ok;
  logic                w_ack_ok_nxt;
  logic                r_idle_seen;
  logic                w_idle_seen_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_err;
  logic                w_err_nxt;

  logic                w_clk_sync;
  logic                w_clk_fe;
  logic                w_data_sync;
  // The transmitter only needs the level of the data line, not its edges.
  logic                w_unused_data_fe;

`ifdef PS2_TX_TIMEOUT_EN
  logic                w_in_frame;
  logic                w_timeout;
  assign w_in_frame = (r_state == SEND) || (r_state == WAIT_IDLE);
  assign w_timeout  = (r_cnt == C_TO_LAST);
`endif

  ps2_line_sync u_clk_sync (
    .clk    (clk),
    .rst_b  (rst_b),
    .i_line (ps2_clk_in),
    .o_sync (w_clk_sync),
    .o_fe   (w_clk_fe)
  );

  ps2_line_sync u_data_sync (
    .clk    (clk),
    .rst_b  (rst_b),
    .i_line (ps2_data_in),
    .o_sync (w_data_sync),
    .o_fe   (w_unused_data_fe)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_parity    <= 1'b0;
      r_clk_oe    <= 1'b0;
      r_data_oe   <= 1'b0;
      r_ack_ok    <= 1'b0;
      r_idle_seen <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_parity    <= w_parity_nxt;
      r_clk_oe    <= w_clk_oe_nxt;
      r_data_oe   <= w_data_oe_nxt;
      r_ack_ok    <= w_ack_ok_nxt;
      r_idle_seen <= w_idle_seen_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_parity_nxt    = r_parity;
    w_clk_oe_nxt    = r_clk_oe;
    w_data_oe_nxt   = r_data_oe;
    w_ack_ok_nxt    = r_ack_ok;
    w_idle_seen_nxt = r_idle_seen;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    // Number of the falling edge being handled right now (1-based).
    w_fe_num        = r_bit_cnt + 4'd1;

    case (r_state)
      IDLE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_cnt_nxt     = '0;
        if (tx_valid) begin
          w_state_nxt   = INHIBIT;
          w_shift_nxt   = tx_data;
          w_parity_nxt  = odd_parity(tx_data);
          w_bit_cnt_nxt = 4'd0;
          w_ack_ok_nxt  = 1'b0;
          w_clk_oe_nxt  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      INHIBIT: begin
        w_clk_oe_nxt  = 1'b1;
        w_data_oe_nxt = 1'b0;
        if (r_cnt == C_INH_LAST) begin
          // Pull data low (start bit) while clock is still held.
          w_state_nxt   = REQ;
          w_cnt_nxt     = '0;
          w_data_oe_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end

      REQ: begin
        w_data_oe_nxt = 1'b1;
        if (r_cnt == C_REQ_LAST) begin
          // Hand the clock over to the device.
          w_state_nxt   = SEND;
          w_clk_oe_nxt  = 1'b0;
          w_bit_cnt_nxt = 4'd0;
          w_cnt_nxt     = '0;
        end else begin
          w_clk_oe_nxt = 1'b1;
          w_cnt_nxt    = r_cnt + C_ONE;
        end
      end

      SEND: begin
        w_clk_oe_nxt = 1'b0;
        if (w_clk_fe) begin
          w_bit_cnt_nxt = w_fe_num;
          if (w_fe_num <= PS2_LAST_DATA) begin
            // LSB first: drive the inverse since oe=1 means line low.
            w_data_oe_nxt = ~r_shift[0];
            w_shift_nxt   = {1'b0, r_shift[7:1]};
          end else if (w_fe_num == PS2_PARITY_FE) begin
            w_data_oe_nxt = ~r_parity;
          end else if (w_fe_num == PS2_STOP_FE) begin
            w_data_oe_nxt = 1'b0;
          end else if (w_fe_num == PS2_ACK_FE) begin
            w_data_oe_nxt   = 1'b0;
            w_ack_ok_nxt    = ~w_data_sync;
            w_idle_seen_nxt = 1'b0;
            w_state_nxt     = WAIT_IDLE;
          end else begin
            w_data_oe_nxt = 1'b0;
            w_state_nxt   = WAIT_IDLE;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt;
        end
      end

      WAIT_IDLE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (w_clk_sync && w_data_sync) begin
          if (r_idle_seen) begin
            w_done_nxt      = 1'b1;
            w_err_nxt       = ~r_ack_ok;
            w_idle_seen_nxt = 1'b0;
            w_state_nxt     = IDLE;
          end else begin
            w_idle_seen_nxt = 1'b1;
          end
        end else begin
          w_idle_seen_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_cnt_nxt     = '0;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Frame watchdog; overrides any edge handled in the same cycle.
    if (w_in_frame) begin
      if (w_timeout) begin
        w_state_nxt     = IDLE;
        w_clk_oe_nxt    = 1'b0;
        w_data_oe_nxt   = 1'b0;
        w_done_nxt      = 1'b1;
        w_err_nxt       = 1'b1;
        w_ack_ok_nxt    = 1'b0;
        w_idle_seen_nxt = 1'b0;
        w_cnt_nxt       = '0;
      end else begin
        w_cnt_nxt = r_cnt + C_ONE;
      end
    end else begin
      // Outside the frame the state decode above owns the counter.
      w_cnt_nxt = w_cnt_nxt;
    end
`endif
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign done        = r_done;
  assign err         = r_err;
  assign ack_ok      = r_ack_ok;
  assign tx_ready    = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign rx_inhibit  = busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a simple PS/2 device model on the
// open-drain pair. Timeout scenario runs only with PS2_TX_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       rx_inhibit;
  logic       done;
  logic       ack_ok;
  logic       err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       bus_clk;
  logic       bus_data;

  assign bus_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign bus_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (100),
    .REQ_CYCLES     (10),
    .TIMEOUT_CYCLES (5000),
    .CNT_SIZE       (20)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (bus_clk),
    .ps2_data_in (bus_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .rx_inhibit  (rx_inhibit),
    .done        (done),
    .ack_ok      (ack_ok),
    .err         (err)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Bus monitor, sampled on the falling clock edge.
  int   cyc = 0;
  int   rel_cyc = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   inh_cnt = 0;
  int   accept_cnt = 0;
  int   accepts_at_done = 0;
  logic done_ack = 1'b0;
  logic done_err = 1'b0;
  logic done_clk_oe = 1'b0;
  logic done_data_oe = 1'b0;
  logic prev_clk_oe = 1'b0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc         <= cyc + 1;
    prev_clk_oe <= ps2_clk_oe;
    prev_busy   <= busy;
    if (prev_clk_oe && !ps2_clk_oe) rel_cyc <= cyc;
    if (ps2_clk_oe && !ps2_data_oe) inh_cnt <= inh_cnt + 1;
    if (busy && !prev_busy) accept_cnt <= accept_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done) begin
      done_cnt        <= done_cnt + 1;
      done_cyc        <= cyc;
      done_ack        <= ack_ok;
      done_err        <= err;
      done_clk_oe     <= ps2_clk_oe;
      done_data_oe    <= ps2_data_oe;
      accepts_at_done <= accept_cnt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s wait bound expired", tag);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound, input string tag);
    int t = 0;
    while (done_cnt == base && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == base) bound_fail(tag);
  endtask

  task automatic wait_busy(input int bound, input string tag);
    int t = 0;
    while (!busy && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (!busy) bound_fail(tag);
  endtask

  // Device model: waits for the request-to-send, then clocks n_edges falling
  // edges, sampling the data line late in each low half. line[0] is the
  // start bit, [1..8] data, [9] parity, [10] stop.
  task automatic dev_frame(input int n_edges, input bit ack, input int rst_at,
                           output logic [10:0] line, output logic par_oe);
    int t;
    line   = 11'd0;
    par_oe = 1'b0;
    t = 0;
    while (!ps2_clk_oe && t < 2000) begin @(negedge clk); t++; end
    if (!ps2_clk_oe) begin bound_fail("dev_inhibit"); return; end
    t = 0;
    while (ps2_clk_oe && t < 2000) begin @(negedge clk); t++; end
    if (ps2_clk_oe) begin bound_fail("dev_release"); return; end
    repeat (5) @(negedge clk);
    line[0] = bus_data;
    for (int k = 1; k <= n_edges; k++) begin
      dev_clk_low = 1'b1;
      if (k == rst_at) begin
        repeat (8) @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("rst_async_clk_oe", ps2_clk_oe, 1'b0);
        chk("rst_async_data_oe", ps2_data_oe, 1'b0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (5) @(negedge clk);
        rst_b = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
      if (k <= 10) line[k] = bus_data;
      if (k == 9) par_oe = ps2_data_oe;
      dev_clk_low = 1'b0;
      if (k == 10 && ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  initial begin
    logic [10:0] line;
    logic        par_oe;
    int          b_done;
    int          b_err;
    int          b_inh;
    int          b_acc;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_data_oe", ps2_data_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ack_ok", ack_ok, 1'b0);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1'b1);

    // Normal send of 0xED with ACK
    b_done = done_cnt; b_err = err_cnt; b_inh = inh_cnt;
    send_byte(8'hED);
    chk("ed_busy", busy, 1'b1);
    chk("ed_rx_inhibit", rx_inhibit, 1'b1);
    dev_frame(11, 1'b1, 0, line, par_oe);
    wait_done(b_done, 500, "ed_done_wait");
    chk("ed_inhibit_len", inh_cnt - b_inh, 100);
    chk("ed_frame", line, {1'b1, 1'b1, 8'hED, 1'b0});
    chk("ed_done_cnt", done_cnt - b_done, 1);
    chk("ed_ack_ok", done_ack, 1'b1);
    chk("ed_err", done_err, 1'b0);
    chk("ed_err_cnt", err_cnt - b_err, 0);
    repeat (2) @(negedge clk);
    chk("ed_tx_ready", tx_ready, 1'b1);

    // Parity: 0x00 -> parity 1 (released), 0x01 -> parity 0 (pulled)
    b_done = done_cnt;
    send_byte(8'h00);
    dev_frame(11, 1'b1, 0, line, par_oe);
    wait_done(b_done, 500, "p00_done_wait");
    chk("p00_frame", line, {1'b1, 1'b1, 8'h00, 1'b0});
    chk("p00_par_oe", par_oe, 1'b0);
    b_done = done_cnt;
    send_byte(8'h01);
    dev_frame(11, 1'b1, 0, line, par_oe);
    wait_done(b_done, 500, "p01_done_wait");
    chk("p01_frame", line, {1'b1, 1'b0, 8'h01, 1'b0});
    chk("p01_par_oe", par_oe, 1'b1);
    chk("p01_ack_ok", done_ack, 1'b1);

    // NACK on 0xFF
    b_done = done_cnt; b_err = err_cnt;
    send_byte(8'hFF);
    dev_frame(11, 1'b0, 0, line, par_oe);
    wait_done(b_done, 500, "nack_done_wait");
    chk("nack_frame", line, {1'b1, 1'b1, 8'hFF, 1'b0});
    chk("nack_ack_ok", done_ack, 1'b0);
    chk("nack_err_with_done", done_err, 1'b1);
    chk("nack_err_cnt", err_cnt - b_err, 1);

`ifdef PS2_TX_TIMEOUT_EN
    // Timeout: device stops after fe 4
    b_done = done_cnt;
    send_byte(8'h5A);
    dev_frame(4, 1'b0, 0, line, par_oe);
    wait_done(b_done, 6000, "to_done_wait");
    chk("to_latency", done_cyc - rel_cyc, 5000);
    chk("to_err", done_err, 1'b1);
    chk("to_ack_ok", done_ack, 1'b0);
    chk("to_clk_oe", done_clk_oe, 1'b0);
    chk("to_data_oe", done_data_oe, 1'b0);
    repeat (2) @(negedge clk);
    chk("to_idle", tx_ready, 1'b1);
`endif

    // Reset at fe 6, then a clean 0xF4 send
    b_done = done_cnt;
    send_byte(8'hED);
    dev_frame(11, 1'b1, 6, line, par_oe);
    repeat (10) @(negedge clk);
    chk("rmid_no_done", done_cnt - b_done, 0);
    chk("rmid_tx_ready", tx_ready, 1'b1);
    chk("rmid_busy", busy, 1'b0);
    b_done = done_cnt;
    send_byte(8'hF4);
    dev_frame(11, 1'b1, 0, line, par_oe);
    wait_done(b_done, 500, "f4_done_wait");
    chk("f4_frame", line, {1'b1, 1'b0, 8'hF4, 1'b0});
    chk("f4_ack_ok", done_ack, 1'b1);

    // Back-pressure: valid held high across two bytes
    b_done = done_cnt; b_acc = accept_cnt;
    @(negedge clk);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    wait_busy(10, "bp_first_accept");
    tx_data = 8'h55;
    dev_frame(11, 1'b1, 0, line, par_oe);
    wait_done(b_done, 500, "bp1_done_wait");
    chk("bp_one_accept_before_done", accepts_at_done - b_acc, 1);
    chk("bp1_frame", line, {1'b1, 1'b1, 8'hAA, 1'b0});
    b_done = done_cnt;
    wait_busy(10, "bp_second_accept");
    tx_valid = 1'b0;
    dev_frame(11, 1'b1, 0, line, par_oe);
    wait_done(b_done, 500, "bp2_done_wait");
    chk("bp2_frame", line, {1'b1, 1'b1, 8'h55, 1'b0});
    chk("bp_accepts", accept_cnt - b_acc, 2);
    chk("bp2_ack_ok", done_ack, 1'b1);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
